// File: rtl/monitor_eval_scheduler.sv
// monitor_eval_scheduler: sequences stream-monitor evaluations. Each evaluation
// is started either by an event popped from the input queue or by a periodic
// deadline, and then walks through the evaluation layers one cycle at a time.
// Deadlines win over events. A deadline that is still pending when the next one
// fires sets a sticky overrun flag. All outputs are driven straight from flops.
module monitor_eval_scheduler #(
  parameter int                         NUM_IN       = 2,
  parameter int                         NUM_OUT      = 6,
  parameter int                         NUM_LAYERS   = 3,
  parameter int                         PERIOD       = 500,
  parameter logic [2*NUM_OUT-1:0]       OUT_LAYER    = '0,
  parameter logic [NUM_OUT-1:0]         OUT_PERIODIC = '0,
  parameter logic [NUM_IN*NUM_OUT-1:0]  OUT_DEP      = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_pop_valid,
  input  logic [NUM_IN-1:0]  q_new_in,
  output logic               q_pop,
  output logic [NUM_IN-1:0]  enable_in,
  output logic [NUM_OUT-1:0] enable_out,
  output logic               slide_0,
  output logic               busy,
  output logic               eval_done,
  output logic               overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POP  = 3'd1;
  localparam logic [2:0] S_PER  = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic MODE_EVENT    = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam logic [1:0] LAST_LYR = 2'(NUM_LAYERS - 1);
  localparam int         CW       = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);

  logic [2:0]        state, state_d;
  logic [1:0]        lyr, lyr_d;
  logic              mode, mode_d;
  logic [NUM_IN-1:0] cap_in, cap_d;
  logic [CW-1:0]     cnt;
  logic              dl_pend;
  logic              take_dl;
  logic              wrap;
  logic [NUM_OUT-1:0] en_out_d;

  assign wrap = (cnt == CNT_MAX);

  // Next-state decode; a pending deadline is consumed as IDLE hands over to PER
  always_comb begin
    state_d = state;
    lyr_d   = lyr;
    mode_d  = mode;
    cap_d   = cap_in;
    take_dl = 1'b0;
    case (state)
      S_IDLE: begin
        if (dl_pend) begin
          state_d = S_PER;
          take_dl = 1'b1;
        end else if (q_pop_valid) begin
          state_d = S_POP;
          cap_d   = q_new_in;
        end
      end
      S_POP: begin
        state_d = S_EVAL;
        mode_d  = MODE_EVENT;
        lyr_d   = '0;
      end
      S_PER: begin
        state_d = S_EVAL;
        mode_d  = MODE_PERIODIC;
        lyr_d   = '0;
      end
      S_EVAL: begin
        if (lyr == LAST_LYR) begin
          state_d = S_DONE;
        end else begin
          lyr_d = lyr + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        lyr_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        lyr_d   = '0;
      end
    endcase
  end

  // Output-enable selection for the layer that the next cycle will evaluate
  always_comb begin
    en_out_d = '0;
    if (state_d == S_EVAL) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (OUT_LAYER[2*o +: 2] == lyr_d) begin
          if (mode_d == MODE_PERIODIC) begin
            en_out_d[o] = OUT_PERIODIC[o];
          end else begin
            en_out_d[o] = !OUT_PERIODIC[o] && (|(OUT_DEP[NUM_IN*o +: NUM_IN] & cap_d));
          end
        end
      end
    end
  end

  // Free-running deadline timer; a fire while one is already pending is an overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      dl_pend <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + CW'(1);
      dl_pend <= wrap | (dl_pend & ~take_dl);
      overrun <= overrun | (wrap & dl_pend);
    end
  end

  // Sequencer state plus registered copies of every strobe and enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lyr        <= '0;
      mode       <= MODE_EVENT;
      cap_in     <= '0;
      q_pop      <= 1'b0;
      slide_0    <= 1'b0;
      busy       <= 1'b0;
      eval_done  <= 1'b0;
      enable_in  <= '0;
      enable_out <= '0;
    end else begin
      state      <= state_d;
      lyr        <= lyr_d;
      mode       <= mode_d;
      cap_in     <= cap_d;
      q_pop      <= (state_d == S_POP);
      slide_0    <= (state_d == S_PER);
      busy       <= (state_d != S_IDLE);
      eval_done  <= (state_d == S_DONE);
      enable_in  <= (state_d == S_EVAL && lyr_d == 2'd0 && mode_d == MODE_EVENT) ? cap_d : '0;
      enable_out <= en_out_d;
    end
  end

endmodule
